// File: rtl/lms_pkg.sv
// Shared types and fixed-point helpers for the LMS tap bank.
package lms_pkg;

    localparam int unsigned LMS_WIDTH = 16;
    localparam int unsigned LMS_QP    = 12;
    localparam int unsigned LMS_LEN   = 8;

    localparam logic signed [LMS_WIDTH-1:0] SAT_MAX = {1'b0, {(LMS_WIDTH-1){1'b1}}};
    localparam logic signed [LMS_WIDTH-1:0] SAT_MIN = {1'b1, {(LMS_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        WAIT_ERR,
        SCALE,
        UPDATE
    } state_t;

    // Full-precision signed product with arithmetic right shift by qp; operands up to 32 bits.
    function automatic logic signed [63:0] mul_shift(input logic signed [31:0] a,
                                                     input logic signed [31:0] b,
                                                     input int unsigned qp);
        logic signed [63:0] aw;
        logic signed [63:0] bw;
        aw = 64'(a);
        bw = 64'(b);
        return (aw * bw) >>> qp;
    endfunction

endpackage

// File: rtl/tap_update_mac.sv
// Shared multiply-shift-add for mu*e scaling and weight update.
// LMS_SAT_EN: saturate results to the signed WIDTH range instead of wrapping.
module tap_update_mac
    import lms_pkg::*;
#(
    parameter int unsigned WIDTH = LMS_WIDTH,
    parameter int unsigned QP    = LMS_QP
) (
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] b,
    input  logic signed [WIDTH-1:0] addend,
    input  logic                    acc,
    output logic signed [WIDTH-1:0] result_c
);

`ifdef LMS_SAT_EN
    localparam longint SAT_HI = (longint'(1) <<< (WIDTH - 1)) - longint'(1);
    localparam longint SAT_LO = -SAT_HI - longint'(1);

    logic signed [63:0]      prod_c;
    logic signed [WIDTH-1:0] inc_c;
    logic signed [63:0]      sum_c;

    // Increment truncation always wraps; only the final value is clipped.
    always_comb begin
        prod_c = mul_shift(32'(a), 32'(b), QP);
        inc_c  = prod_c[WIDTH-1:0];
        sum_c  = acc ? (64'(addend) + 64'(inc_c)) : prod_c;
        if (sum_c > SAT_HI) begin
            result_c = WIDTH'(SAT_HI);
        end else if (sum_c < SAT_LO) begin
            result_c = WIDTH'(SAT_LO);
        end else begin
            result_c = sum_c[WIDTH-1:0];
        end
    end
`else
    logic signed [WIDTH-1:0] prod_c;

    always_comb begin
        prod_c   = WIDTH'(mul_shift(32'(a), 32'(b), QP));
        result_c = acc ? (addend + prod_c) : prod_c;
    end
`endif

endmodule

// File: rtl/lms_tap_bank.sv
// Regressor delay line and LMS weight store with serial one-tap-per-cycle update.
// LMS_SAT_EN: saturating mu_e and weight arithmetic (default wraps).
module lms_tap_bank
    import lms_pkg::*;
#(
    parameter int unsigned WIDTH = LMS_WIDTH,
    parameter int unsigned QP    = LMS_QP,
    parameter int unsigned LEN   = LMS_LEN
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [WIDTH-1:0]       x_in,
    input  logic                   x_valid,
    output logic                   x_ready,
    input  logic [WIDTH-1:0]       err_in,
    input  logic                   err_valid,
    output logic                   err_ready,
    input  logic [WIDTH-1:0]       mu,
    input  logic                   adapt_en,
    output logic [LEN*WIDTH-1:0]   x_packed,
    output logic [LEN*WIDTH-1:0]   w_packed,
    output logic                   vec_valid,
    output logic                   busy
);

    localparam int unsigned IDX_W = $clog2(LEN);

    state_t                  state;
    logic signed [WIDTH-1:0] taps    [LEN];
    logic signed [WIDTH-1:0] weights [LEN];
    logic signed [WIDTH-1:0] err_r;
    logic signed [WIDTH-1:0] mu_r;
    logic signed [WIDTH-1:0] mu_e;
    logic [IDX_W-1:0]        idx;

    logic signed [WIDTH-1:0] mac_a;
    logic signed [WIDTH-1:0] mac_b;
    logic signed [WIDTH-1:0] mac_add;
    logic                    mac_acc;
    logic signed [WIDTH-1:0] mac_res_c;

    for (genvar k = 0; k < LEN; k++) begin : g_pack
        assign x_packed[k*WIDTH +: WIDTH] = taps[k];
        assign w_packed[k*WIDTH +: WIDTH] = weights[k];
    end

    // SCALE forms mu*e; UPDATE accumulates mu_e*x[idx] into w[idx].
    always_comb begin
        mac_a   = mu_r;
        mac_b   = err_r;
        mac_add = '0;
        mac_acc = 1'b0;
        if (state == UPDATE) begin
            mac_a   = mu_e;
            mac_b   = taps[idx];
            mac_add = weights[idx];
            mac_acc = 1'b1;
        end
    end

    tap_update_mac #(
        .WIDTH (WIDTH),
        .QP    (QP)
    ) u_mac (
        .a        (mac_a),
        .b        (mac_b),
        .addend   (mac_add),
        .acc      (mac_acc),
        .result_c (mac_res_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            for (int k = 0; k < int'(LEN); k++) begin
                taps[k]    <= '0;
                weights[k] <= '0;
            end
            err_r     <= '0;
            mu_r      <= '0;
            mu_e      <= '0;
            idx       <= '0;
            x_ready   <= 1'b1;
            err_ready <= 1'b0;
            vec_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (x_valid) begin
                        for (int k = 1; k < int'(LEN); k++) begin
                            taps[k] <= taps[k-1];
                        end
                        taps[0]   <= $signed(x_in);
                        state     <= WAIT_ERR;
                        x_ready   <= 1'b0;
                        err_ready <= 1'b1;
                        vec_valid <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                WAIT_ERR: begin
                    if (err_valid) begin
                        err_r     <= $signed(err_in);
                        mu_r      <= $signed(mu);
                        err_ready <= 1'b0;
                        vec_valid <= 1'b0;
                        if (adapt_en) begin
                            state <= SCALE;
                        end else begin
                            state   <= IDLE;
                            x_ready <= 1'b1;
                            busy    <= 1'b0;
                        end
                    end
                end
                SCALE: begin
                    mu_e  <= mac_res_c;
                    idx   <= '0;
                    state <= UPDATE;
                end
                UPDATE: begin
                    weights[idx] <= mac_res_c;
                    idx          <= idx + IDX_W'(1);
                    if (idx == IDX_W'(LEN - 1)) begin
                        state   <= IDLE;
                        x_ready <= 1'b1;
                        busy    <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lms_tap_bank.sv
// Self-checking bench for lms_tap_bank: cycle model plus directed literal checks.
module tb_lms_tap_bank;

    localparam int W   = 16;
    localparam int QP  = 12;
    localparam int LEN = 8;

    logic             clk;
    logic             rst_n;
    logic [W-1:0]     x_in;
    logic             x_valid;
    logic             x_ready;
    logic [W-1:0]     err_in;
    logic             err_valid;
    logic             err_ready;
    logic [W-1:0]     mu;
    logic             adapt_en;
    logic [LEN*W-1:0] x_packed;
    logic [LEN*W-1:0] w_packed;
    logic             vec_valid;
    logic             busy;

    int total = 0;
    int bad   = 0;
    bit check_on = 0;

    lms_tap_bank #(.WIDTH(W), .QP(QP), .LEN(LEN)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .x_in      (x_in),
        .x_valid   (x_valid),
        .x_ready   (x_ready),
        .err_in    (err_in),
        .err_valid (err_valid),
        .err_ready (err_ready),
        .mu        (mu),
        .adapt_en  (adapt_en),
        .x_packed  (x_packed),
        .w_packed  (w_packed),
        .vec_valid (vec_valid),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- arithmetic helpers ----------------
    function automatic int s16(input logic [15:0] v);
        return int'($signed(v));
    endfunction

    function automatic int wrap16(input longint v);
        logic [15:0] t;
        t = v[15:0];
        return s16(t);
    endfunction

    function automatic int fit(input longint v);
`ifdef LMS_SAT_EN
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return int'(v);
`else
        return wrap16(v);
`endif
    endfunction

    function automatic longint mul_q(input longint a, input longint b);
        return (a * b) >>> QP;
    endfunction

    function automatic int tap(input logic [LEN*W-1:0] v, input int k);
        logic signed [15:0] t;
        t = v[k*W +: W];
        return int'(t);
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_vec(input string name, input logic [LEN*W-1:0] act,
                             input logic [LEN*W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int     xm [LEN];
    int     wm [LEN];
    int     pend_w [LEN];
    longint pend_e [LEN];
    bit     m_wait;
    longint m_free;
    longint edge_cnt = 0;

    function automatic bit m_idle();
        return !m_wait && (edge_cnt + 1 >= m_free);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < LEN; k++) begin
                xm[k] = 0; wm[k] = 0; pend_e[k] = -1; pend_w[k] = 0;
            end
            m_wait = 0;
            m_free = 0;
        end else begin
            int mu_e;
            edge_cnt++;
            for (int k = 0; k < LEN; k++) begin
                if (pend_e[k] == edge_cnt) begin
                    wm[k] = pend_w[k];
                    pend_e[k] = -1;
                end
            end
            if (!m_wait) begin
                if (edge_cnt >= m_free && x_valid) begin
                    for (int k = LEN - 1; k > 0; k--) xm[k] = xm[k-1];
                    xm[0] = s16(x_in);
                    m_wait = 1;
                end
            end else if (err_valid) begin
                m_wait = 0;
                if (adapt_en) begin
                    mu_e = fit(mul_q(longint'(s16(mu)), longint'(s16(err_in))));
                    for (int k = 0; k < LEN; k++) begin
                        pend_w[k] = fit(longint'(wm[k]) +
                                        longint'(wrap16(mul_q(longint'(mu_e), longint'(xm[k])))));
                        pend_e[k] = edge_cnt + 2 + longint'(k);
                    end
                    m_free = edge_cnt + 2 + longint'(LEN);
                end else begin
                    m_free = edge_cnt + 1;
                end
            end
        end
    end

    // Every-cycle comparison against the model, shortly after each rising edge.
    always @(posedge clk) begin
        #1;
        if (check_on) begin
            logic [LEN*W-1:0] ex;
            logic [LEN*W-1:0] ew;
            bit xr;
            for (int k = 0; k < LEN; k++) begin
                ex[k*W +: W] = 16'(xm[k]);
                ew[k*W +: W] = 16'(wm[k]);
            end
            xr = m_idle();
            check_vec("x_packed", x_packed, ex);
            check_vec("w_packed", w_packed, ew);
            check("x_ready", longint'(x_ready), longint'(xr));
            check("err_ready", longint'(err_ready), longint'(m_wait));
            check("vec_valid", longint'(vec_valid), longint'(m_wait));
            check("busy", longint'(busy), longint'(!xr));
        end
    end

    // ---------------- stimulus tasks ----------------
    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (!m_idle() && n < 64) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", longint'(m_idle()), 1);
    endtask

    task automatic push(input int v);
        wait_idle();
        x_in    = 16'(v);
        x_valid = 1'b1;
        @(negedge clk);
        x_valid = 1'b0;
    endtask

    task automatic send_err(input int m, input int e, input bit ad);
        mu        = 16'(m);
        err_in    = 16'(e);
        adapt_en  = ad;
        err_valid = 1'b1;
        @(negedge clk);
        err_valid = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int c;
        rst_n = 1'b0; x_in = '0; x_valid = 1'b0; err_in = '0; err_valid = 1'b0;
        mu = '0; adapt_en = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_x_packed", longint'(x_packed == '0), 1);
        check("rst_w_packed", longint'(w_packed == '0), 1);
        check("rst_x_ready", longint'(x_ready), 1);
        check("rst_err_ready", longint'(err_ready), 0);
        check("rst_vec_valid", longint'(vec_valid), 0);
        check("rst_busy", longint'(busy), 0);
        check_on = 1;

        // Delay line with adaptation disabled
        push(4096); send_err(0, 0, 0);
        push(2048); send_err(0, 0, 0);
        push(1024); send_err(0, 0, 0);
        check("dl_tap0", tap(x_packed, 0), 1024);
        check("dl_tap1", tap(x_packed, 1), 2048);
        check("dl_tap2", tap(x_packed, 2), 4096);
        check("dl_tap3", tap(x_packed, 3), 0);
        check("dl_weights", longint'(w_packed == '0), 1);

        // Single update and x_ready latency
        apply_reset();
        push(4096);
        send_err(2048, 4096, 1);
        c = 1;
        while (!x_ready && c < 20) begin
            @(negedge clk);
            c++;
        end
        check("xready_latency", c, 10);
        check("su_w0", tap(w_packed, 0), 2048);
        check("su_w1", tap(w_packed, 1), 0);
        check("su_w7", tap(w_packed, 7), 0);
        check("model_w0", wm[0], 2048);

        // Overflow of w0
        apply_reset();
        push(4096);
        send_err(4096, 30720, 1);
        wait_idle();
        check("ov_pre_w0", tap(w_packed, 0), 30720);
        push(4096);
        send_err(4096, 4096, 1);
        wait_idle();
`ifdef LMS_SAT_EN
        check("ov_w0", tap(w_packed, 0), 32767);
`else
        check("ov_w0", tap(w_packed, 0), -30720);
`endif
        check("ov_w1", tap(w_packed, 1), 4096);

        // Ignored x_valid during UPDATE and err_valid during IDLE
        push(100);
        send_err(4096, 4096, 1);
        @(negedge clk);
        x_in = 16'(777); x_valid = 1'b1;
        @(negedge clk);
        x_valid = 1'b0;
        wait_idle();
        mu = 16'(4096); err_in = 16'(9999); adapt_en = 1'b1; err_valid = 1'b1;
        @(negedge clk);
        err_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("ign_tap0", tap(x_packed, 0), 100);
        check("ign_tap1", tap(x_packed, 1), 4096);
        check("ign_busy", longint'(busy), 0);

        // Reset while UPDATE is at idx=3
        apply_reset();
        push(4096);
        send_err(4096, 4096, 1);
        repeat (4) @(negedge clk);
        check("mr_pre_w0", tap(w_packed, 0), 4096);
        rst_n = 1'b0;
        #1;
        check("mr_x_packed", longint'(x_packed == '0), 1);
        check("mr_w_packed", longint'(w_packed == '0), 1);
        check("mr_busy", longint'(busy), 0);
        check("mr_x_ready", longint'(x_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        push(1234);
        check("mr_next_tap0", tap(x_packed, 0), 1234);
        check("mr_next_vec_valid", longint'(vec_valid), 1);
        send_err(0, 0, 0);
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lms_tap_bank.md
# lms_tap_bank

Regressor delay line and adaptive weight store for the HSAF linear FIR section. It sits directly upstream of the dot-product stage and drives both of its packed vector inputs: the tap-delayed sample vector and the weight vector. After downstream logic returns the output error, it applies a serial LMS update, w[k] += mu·e·x[k], one tap per cycle through a single shared multiplier. Sample acceptance is handshaked so a new sample never enters mid-update.

## Interface
- WIDTH, 16: signed fixed-point word width of samples, weights, mu and error.
- QP, 12: fractional bits; 1.0 = 2^QP.
- LEN, 8: number of taps, ≥2.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- x_in  in  WIDTH  new input sample (spline-stage output).
- x_valid  in  1  x_in valid.
- x_ready  out  1  bank can accept a sample.
- err_in  in  WIDTH  error for the current sample.
- err_valid  in  1  err_in valid.
- err_ready  out  1  bank waiting for error.
- mu  in  WIDTH  step size, sampled at error accept.
- adapt_en  in  1  sampled at error accept; 0 skips the update.
- x_packed  out  LEN*WIDTH  delay line; tap k at [k*WIDTH +: WIDTH], tap 0 is the newest sample; drives dot-product vec1.
- w_packed  out  LEN*WIDTH  weights, same packing; drives dot-product vec2.
- vec_valid  out  1  x_packed/w_packed are coherent for the current sample.
- busy  out  1  state is not IDLE.

## Operation
- FSM states: IDLE, WAIT_ERR, SCALE, UPDATE.
- IDLE: x_ready=1. When x_valid is high, shift the line (tap k ← tap k-1, tap 0 ← x_in, tap LEN-1 dropped) and go to WAIT_ERR.
- WAIT_ERR: vec_valid=1, err_ready=1. When err_valid is high, latch err_in, mu and adapt_en. If adapt_en=0, go to IDLE. Otherwise go to SCALE.
- SCALE: mu_e = (mu·err) >>> QP, computed from the full 2·WIDTH product, truncated to WIDTH. Clear idx and go to UPDATE.
- UPDATE: w[idx] ← w[idx] + ((mu_e·x[idx]) >>> QP). The product is full 2·WIDTH, shifted arithmetically, and truncated to WIDTH. The sum wraps modulo 2^WIDTH unless saturation is enabled. idx increments each cycle; after idx = LEN-1, go to IDLE.
- The delay line is frozen outside IDLE.
- x_valid outside IDLE is ignored, with no shift. err_valid outside WAIT_ERR is ignored.
- The update uses the x vector as it was when the error was accepted.

## Timing
- Reset values: every delay-line tap and weight = 0; state = IDLE; x_ready=1; err_ready=0; vec_valid=0; busy=0; idx=0.
- Sample accepted at edge t: x_packed is updated and vec_valid=1 from cycle t+1. The downstream dot product is combinational, so its result is valid in the same cycle.
- Error accepted at edge n, with adapt_en=1:
  - cycle n+1 is SCALE;
  - cycles n+2 … n+1+LEN are UPDATE, and w[k] is written at the end of cycle n+2+k;
  - x_ready=1 again in cycle n+2+LEN.
- Error accepted with adapt_en=0: x_ready=1 in cycle n+1 and weights are unchanged.
- Maximum throughput: one sample per LEN+3 cycles with adaptation, one per 2 without. This assumes an error return with zero wait.
- Reset asserted mid-operation: all state clears immediately and asynchronously. A pending error is discarded.
- x_valid and err_valid high together: only the one matching the current state is honoured.

## Configuration
- LMS_SAT_EN defined: the weight update sum saturates to [-2^(WIDTH-1), 2^(WIDTH-1)-1]. The mu_e truncation also saturates.
- Undefined: both wrap two's-complement, matching the dot-product arithmetic.

## Structure
- Shared package lms_pkg:
  - state enum {IDLE, WAIT_ERR, SCALE, UPDATE};
  - a fixed-point multiply-shift function;
  - SAT_MAX/SAT_MIN constants derived from WIDTH.
- One sub-module: tap_update_mac. It holds the shared multiplier, the shift, and the adder with optional saturation. It is used for both the SCALE and UPDATE computations.

## Test plan
WIDTH=16, QP=12, LEN=8 unless noted.
- Reset: after reset, all packed outputs = 0, x_ready=1, err_ready=0, vec_valid=0, busy=0.
- Delay line: push 4096, 2048, 1024 with adapt_en=0 → tap0=1024, tap1=2048, tap2=4096, others 0; weights remain 0.
- Single update: from reset, push x=4096, then mu=2048, err=4096, adapt_en=1 → mu_e=2048; w0=2048, w1..w7=0. x_ready returns exactly 10 cycles after the error-accept edge.
- Overflow: w0=30720 and an increment of 4096 → w0=32767 with LMS_SAT_EN; w0=-30720 without it.
- Ignored inputs: pulse x_valid during UPDATE and err_valid during IDLE → no shift and no weight change.
- Reset mid-UPDATE at idx=3 → all taps and weights are 0 immediately, state is IDLE, and the next sample is accepted normally.
